frame_sequencer: RTL and testbench

Per-frame scheduler for the dino game datapath. Divides the system clock into a fixed frame period and runs each frame in two exclusive phases: a single game-logic update (start/done handshake), then a full 160x120 pixel sweep driving the VGA adapter's x/y/plot inputs. It replaces the free-running frame divider and self-starting renderer. Game logic and renderer never run in the same cycle.

---
 rtl/dino_pkg.sv | 19 +
 rtl/frame_divider.sv | 37 +++
 rtl/frame_sequencer.sv | 135 +++++++++++++
 tb/tb_frame_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the dino game datapath: frame sequencer state
// encoding and the screen geometry used by both the sequencer and the
// pixel renderer.
package dino_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_RENDER = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

  // Screen geometry (160 x 120 pixels).
  localparam int SCREEN_X_MAX = 159;
  localparam int SCREEN_Y_MAX = 119;
  localparam int PIXEL_COUNT  = 19200;

endpackage

// File: rtl/frame_divider.sv
// Free-running frame divider. Counts 0..FRAME_CYCLES-1 and flags the last
// cycle of every frame with tick; it never stalls, whatever the sequencer
// is doing, so frame boundaries stay locked to the system clock.
module frame_divider #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Frame cycle counter, wraps to zero after the last cycle of the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (count == LAST) begin
      count <= {CNT_W{1'b0}};
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Tick marks the final cycle of each frame.
  always_comb begin
    if (count == LAST) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler for the dino game. Each frame tick runs an optional
// game-logic update (start/done handshake with a bounded wait) followed by
// a full pixel sweep for the VGA adapter. The two phases are exclusive, so
// game logic and renderer never touch shared state in the same cycle.
module frame_sequencer
  import dino_pkg::*;
#(
  parameter int FRAME_CYCLES   = 833333,
  parameter int UPDATE_TIMEOUT = 255,
  parameter int X_MAX          = SCREEN_X_MAX,
  parameter int Y_MAX          = SCREEN_Y_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        update_done,
  output logic        update_start,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic        plot,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        overrun,
  output logic        upd_timeout
);

  // Wait counter must be able to hold UPDATE_TIMEOUT itself.
  localparam int WAIT_W = (UPDATE_TIMEOUT > 0) ? $clog2(UPDATE_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(UPDATE_TIMEOUT);
  localparam logic [7:0] X_LAST = 8'(X_MAX);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX);

  logic              tick;
  seq_state_t        state;
  logic [WAIT_W-1:0] wait_count;

  frame_divider #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_divider (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Frame FSM with all handshake, sweep and status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_count   <= {WAIT_W{1'b0}};
      update_start <= 1'b0;
      x            <= 8'd0;
      y            <= 7'd0;
      plot         <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= 16'd0;
      overrun      <= 1'b0;
      upd_timeout  <= 1'b0;
    end else begin
      // Pulse outputs default low; the state that needs them raises them.
      update_start <= 1'b0;
      frame_done   <= 1'b0;

      // A tick that finds the sequencer busy is dropped: that frame is skipped.
      if (tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // run is only looked at here, on the tick cycle.
          if (tick) begin
            if (run) begin
              state        <= ST_UPDATE;
              update_start <= 1'b1;
              wait_count   <= {WAIT_W{1'b0}};
            end else begin
              state <= ST_RENDER;
              plot  <= 1'b1;
              x     <= 8'd0;
              y     <= 7'd0;
            end
          end
        end

        ST_UPDATE: begin
          // A done pulse takes priority over the timeout in the same cycle.
          if (update_done) begin
            state <= ST_RENDER;
            plot  <= 1'b1;
            x     <= 8'd0;
            y     <= 7'd0;
          end else if (wait_count == WAIT_LAST) begin
            state       <= ST_RENDER;
            plot        <= 1'b1;
            x           <= 8'd0;
            y           <= 7'd0;
            upd_timeout <= 1'b1;
          end else begin
            wait_count <= wait_count + WAIT_W'(1);
          end
        end

        ST_RENDER: begin
          // Raster order: x runs fastest, y advances at the end of a row.
          if (x == X_LAST) begin
            x <= 8'd0;
            if (y == Y_LAST) begin
              state       <= ST_DONE;
              plot        <= 1'b0;
              y           <= 7'd0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              y <= y + 7'd1;
            end
          end else begin
            x <= x + 8'd1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          plot  <= 1'b0;
          x     <= 8'd0;
          y     <= 7'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer. Three instances run side by side:
//   a: FRAME_CYCLES=19500, UPDATE_TIMEOUT=8   (handshake, timeout, run=0)
//   b: FRAME_CYCLES=19300, UPDATE_TIMEOUT=255 (long update forces overrun)
//   c: FRAME_CYCLES=19500, UPDATE_TIMEOUT=8   (reset mid-sweep at (80,60))
// Each instance is compared every cycle against a timestamp-based model of
// the frame schedule; update_done is driven randomly outside update phases.
module tb_frame_sequencer;

  localparam int COLS       = 160;
  localparam int ROWS       = 120;
  localparam int PIXELS     = COLS * ROWS;
  localparam int RESET_PIX  = 60 * COLS + 80;
  localparam int RUN_CYCLES = 78000;
  localparam int NFRM       = 5;

  typedef struct packed {
    int cyc;       // cycles since last reset
    int ticks;     // ticks seen (stimulus bookkeeping, survives reset)
    bit active;    // a frame is in progress (sequencer not idle)
    int t_tick;    // cycle of the tick that started the frame
    bit upd;       // frame has an update phase
    int t_render;  // cycle of first plot, -1 while still updating
    bit tmo;
    bit ovr;
    int cnt;
  } mdl_t;

  logic clk = 1'b0;
  logic [2:0]  reset, run, update_done;
  logic [2:0]  update_start, plot, frame_done, overrun, upd_timeout;
  logic [7:0]  x [3];
  logic [6:0]  y [3];
  logic [15:0] frame_count [3];

  int   fc_of [3] = '{19500, 19300, 19500};
  int   ut_of [3] = '{8, 255, 8};
  mdl_t m [3];
  bit   cfg_run [3][NFRM];
  int   cfg_dly [3][NFRM];
  int   dly_now [3];
  bit   c_reset_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  frame_sequencer #(.FRAME_CYCLES(19500), .UPDATE_TIMEOUT(8), .X_MAX(159), .Y_MAX(119)) dut_a (
    .clk(clk), .reset(reset[0]), .run(run[0]), .update_done(update_done[0]),
    .update_start(update_start[0]), .x(x[0]), .y(y[0]), .plot(plot[0]),
    .frame_done(frame_done[0]), .frame_count(frame_count[0]),
    .overrun(overrun[0]), .upd_timeout(upd_timeout[0]));

  frame_sequencer #(.FRAME_CYCLES(19300), .UPDATE_TIMEOUT(255), .X_MAX(159), .Y_MAX(119)) dut_b (
    .clk(clk), .reset(reset[1]), .run(run[1]), .update_done(update_done[1]),
    .update_start(update_start[1]), .x(x[1]), .y(y[1]), .plot(plot[1]),
    .frame_done(frame_done[1]), .frame_count(frame_count[1]),
    .overrun(overrun[1]), .upd_timeout(upd_timeout[1]));

  frame_sequencer #(.FRAME_CYCLES(19500), .UPDATE_TIMEOUT(8), .X_MAX(159), .Y_MAX(119)) dut_c (
    .clk(clk), .reset(reset[2]), .run(run[2]), .update_done(update_done[2]),
    .update_start(update_start[2]), .x(x[2]), .y(y[2]), .plot(plot[2]),
    .frame_done(frame_done[2]), .frame_count(frame_count[2]),
    .overrun(overrun[2]), .upd_timeout(upd_timeout[2]));

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] observed(input int i);
    return {update_start[i], plot[i], x[i], y[i], frame_done[i],
            frame_count[i], overrun[i], upd_timeout[i]};
  endfunction

  function automatic mdl_t model_reset(input int keep_ticks);
    mdl_t r;
    r = '0;
    r.ticks    = keep_ticks;
    r.t_tick   = -1;
    r.t_render = -1;
    return r;
  endfunction

  // Expected outputs for the model's current cycle, from the frame timestamps.
  function automatic logic [35:0] expect_out(input mdl_t s);
    int k;
    logic us, pl, fd;
    logic [7:0] ex;
    logic [6:0] ey;
    us = 1'b0; pl = 1'b0; fd = 1'b0; ex = 8'd0; ey = 7'd0;
    if (s.active) begin
      us = s.upd && (s.cyc == s.t_tick + 1);
      if (s.t_render >= 0) begin
        k = s.cyc - s.t_render;
        if (k >= 0 && k < PIXELS) begin
          pl = 1'b1;
          ex = 8'(k % COLS);
          ey = 7'(k / COLS);
        end
        fd = (k == PIXELS);
      end
    end
    return {us, pl, ex, ey, fd, 16'(s.cnt), s.ovr, s.tmo};
  endfunction

  // Advance the model by one cycle given that cycle's inputs.
  function automatic mdl_t step(input mdl_t s, input int fc, input int ut,
                                input bit rst, input bit run_in, input bit done_in);
    bit busy, tick;
    if (rst) return model_reset(s.ticks);
    busy = s.active;
    tick = (s.cyc % fc) == fc - 1;
    if (s.active && s.upd && s.t_render < 0 && s.cyc > s.t_tick) begin
      if (done_in) begin
        s.t_render = s.cyc + 1;
      end else if (s.cyc - (s.t_tick + 1) == ut) begin
        s.t_render = s.cyc + 1;
        s.tmo = 1'b1;
      end
    end
    if (s.active && s.t_render >= 0) begin
      if (s.cyc == s.t_render + PIXELS - 1) s.cnt = (s.cnt + 1) % 65536;
      if (s.cyc == s.t_render + PIXELS) s.active = 1'b0;
    end
    if (tick) begin
      s.ticks++;
      if (busy) begin
        s.ovr = 1'b1;
      end else begin
        s.active   = 1'b1;
        s.t_tick   = s.cyc;
        s.upd      = run_in;
        s.t_render = run_in ? -1 : s.cyc + 1;
      end
    end
    s.cyc++;
    return s;
  endfunction

  // Choose this cycle's inputs for instance i, drive them, advance its model.
  task automatic drive_and_step(input int i);
    bit rst_v, run_v, done_v, in_upd;
    int f;
    rst_v = (i == 2) && !c_reset_done && m[i].active && m[i].t_render >= 0 &&
            (m[i].cyc - m[i].t_render == RESET_PIX);
    if (rst_v) c_reset_done = 1'b1;
    if ((m[i].cyc % fc_of[i]) == fc_of[i] - 1) begin
      f = (m[i].ticks < NFRM) ? m[i].ticks : NFRM - 1;
      run_v = cfg_run[i][f];
      if (!m[i].active) dly_now[i] = cfg_dly[i][f];
    end else begin
      run_v = 1'($urandom_range(0, 1));
    end
    in_upd = m[i].active && m[i].upd && m[i].t_render < 0 && m[i].cyc > m[i].t_tick;
    if (in_upd) done_v = (dly_now[i] >= 0) && (m[i].cyc == m[i].t_tick + 1 + dly_now[i]);
    else        done_v = ($urandom_range(0, 15) == 0);
    reset[i]       = rst_v;
    run[i]         = run_v;
    update_done[i] = done_v;
    m[i] = step(m[i], fc_of[i], ut_of[i], rst_v, run_v, done_v);
  endtask

  initial begin
    int pc_a, pc_c, us_b, first_us_a;
    pc_a = 0; pc_c = 0; us_b = 0; first_us_a = -1;
    c_reset_done = 1'b0;
    reset = 3'b111; run = 3'b000; update_done = 3'b000;
    for (int i = 0; i < 3; i++) begin
      m[i] = model_reset(0);
      dly_now[i] = -1;
      for (int f = 0; f < NFRM; f++) begin
        cfg_run[i][f] = 1'($urandom_range(0, 1));
        cfg_dly[i][f] = int'($urandom_range(0, 7));
      end
    end
    // a: quick handshake, then a timeout frame, then a run=0 frame
    cfg_run[0][0] = 1'b1; cfg_dly[0][0] = 3;
    cfg_run[0][1] = 1'b1; cfg_dly[0][1] = -1;
    cfg_run[0][2] = 1'b0;
    // b: long update overruns into the next tick; next frame done in start cycle
    cfg_run[1][0] = 1'b1; cfg_dly[1][0] = 150;
    cfg_run[1][2] = 1'b1; cfg_dly[1][2] = 0;
    cfg_run[1][3] = 1'b0;
    // c: run=0 frame, interrupted by reset mid-sweep
    cfg_run[2][0] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < RUN_CYCLES; n++) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("dut%0d cyc %0d", i, n), observed(i), expect_out(m[i]));
      end
      if (update_start[0] && first_us_a < 0) first_us_a = n;
      if (update_start[1]) us_b++;
      if (plot[0]) pc_a++;
      if (frame_done[0]) begin
        check("a_plots_per_frame", 36'(pc_a), 36'(PIXELS));
        pc_a = 0;
      end
      if (plot[2]) pc_c++;
      if (frame_done[2]) begin
        check("c_plots_after_reset", 36'(pc_c), 36'(PIXELS));
        pc_c = 0;
      end
      for (int i = 0; i < 3; i++) drive_and_step(i);
      if (reset[2]) pc_c = 0;
      @(negedge clk);
    end

    check("a_first_update_start", 36'(first_us_a), 36'(19500));
    check("a_frame_count", 36'(frame_count[0]), 36'(3));
    check("a_upd_timeout", 36'(upd_timeout[0]), 36'(1));
    check("a_overrun", 36'(overrun[0]), 36'(0));
    check("b_overrun", 36'(overrun[1]), 36'(1));
    check("b_update_starts", 36'(us_b), 36'(2));
    check("b_frame_count", 36'(frame_count[1]), 36'(2));
    check("c_frame_count", 36'(frame_count[2]), 36'(1));
    check("c_reset_applied", 36'(c_reset_done), 36'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
